// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: FSM state type and default sizing shared by the RAM arbiter files.
package ram_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;
  localparam int DEF_N_CORES   = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RAM_DEPTH = 256;
  localparam int DEF_LOCK_MAX  = 64;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching upward from last+1 with wrap.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // walk from farthest to nearest so the closest requester after i_last wins
    for (int k = N; k >= 1; k--)
      if (i_req[(int'(i_last) + k) % N]) o_idx = IW'((int'(i_last) + k) % N);
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving N PLC cores single-cycle access to a shared RAM,
// with a lock hold for read-modify-write and an idle-hold timeout.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_CORES   = DEF_N_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int LOCK_MAX  = DEF_LOCK_MAX
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_CORES-1:0]          i_req,
  input  logic [N_CORES-1:0]          i_we,
  input  logic [N_CORES-1:0]          i_lock,
  input  logic [N_CORES*ADDR_W-1:0]   i_addr,
  input  logic [N_CORES*DATA_W-1:0]   i_wdata,
  output logic [N_CORES-1:0]          o_ack,
  output logic                        o_err,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [$clog2(N_CORES)-1:0]  o_gnt_id,
  output logic                        o_ram_en,
  output logic                        o_ram_we,
  output logic [ADDR_W-1:0]           o_ram_addr,
  inout  wire  [DATA_W-1:0]           io_ram_data
);
  localparam int IW = $clog2(N_CORES);
  localparam int CW = $clog2(LOCK_MAX + 1);

  state_t              r_state;
  logic [IW-1:0]       r_gnt;
  logic [IW-1:0]       r_last;
  logic [CW-1:0]       r_cnt;
  logic [N_CORES-1:0]  r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [N_CORES-1:0]  w_req;
  logic                w_valid;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_sel;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_go;

  // the core being acknowledged cannot win again in its own ACK cycle
  assign w_req  = i_req & ~r_ack;
  assign w_sel  = (r_state == S_HOLD) ? r_gnt : w_idx;
  assign w_addr = i_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_go   = (r_state == S_IDLE && w_valid) || (r_state == S_HOLD && w_req[r_gnt]);

  rr_picker #(.N(N_CORES)) u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last     <= IW'(N_CORES - 1);
      r_cnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_wdata    <= '0;
    end else begin
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (w_go) begin
        r_state    <= S_ACCESS;
        r_gnt      <= w_sel;
        r_ram_en   <= 32'(w_addr) < RAM_DEPTH;
        r_ram_we   <= i_we[w_sel];
        r_ram_addr <= w_addr;
        r_wdata    <= i_wdata[w_sel*DATA_W +: DATA_W];
      end else if (r_state == S_ACCESS) begin
        r_ram_en      <= 1'b0;
        r_ram_we      <= 1'b0;
        r_ram_addr    <= '0;
        r_ack[r_gnt]  <= 1'b1;
        r_err         <= !r_ram_en;
        r_rdata       <= (r_ram_en && !r_ram_we) ? io_ram_data : '0;
        r_last        <= r_gnt;
        r_cnt         <= '0;
        r_state       <= i_lock[r_gnt] ? S_HOLD : S_IDLE;
      end else if (r_state == S_HOLD && (!i_lock[r_gnt] || r_cnt == CW'(LOCK_MAX - 1))) begin
        // voluntary release is silent; a timeout reports itself with ACK+ERR
        r_state      <= S_IDLE;
        r_ack[r_gnt] <= i_lock[r_gnt];
        r_err        <= i_lock[r_gnt];
      end else if (r_state == S_HOLD) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign io_ram_data = (r_state == S_ACCESS && r_ram_we) ? r_wdata : 'z;
  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_gnt_id    = r_gnt;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  localparam int N = 4, AW = 16, DW = 8, DEPTH = 256, LMAX = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, we = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] o_ack;
  logic o_err, o_ram_en, o_ram_we;
  logic [DW-1:0] o_rdata;
  logic [1:0] o_gnt_id;
  logic [AW-1:0] o_ram_addr;
  tri1 [DW-1:0] ram_data;
  logic [DW-1:0] ram [DEPTH];
  int n_chk = 0, n_err = 0;

  ram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RAM_DEPTH(DEPTH), .LOCK_MAX(LMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr),
    .i_wdata(wdata), .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_gnt_id(o_gnt_id),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .io_ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // external RAM: asynchronous read onto the bus, synchronous write from it
  assign ram_data = (o_ram_en && !o_ram_we) ? ram[o_ram_addr[7:0]] : 8'hzz;
  always @(posedge clk) if (o_ram_en && o_ram_we) ram[o_ram_addr[7:0]] <= ram_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model: which core accesses next cycle, who owns a lock, what gets acked
  int m_acc = -1, m_own = -1, m_idle = 0, m_last = N - 1, m_gnt = 0;
  logic m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [N-1:0] m_ack = '0;
  logic m_err = 1'b0, m_rd_chk = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] mem [DEPTH];
  bit known [DEPTH];

  task automatic m_take(input int c);
    m_acc  = c;
    m_gnt  = c;
    m_we   = we[c];
    m_addr = addr[c*AW +: AW];
    m_wd   = wdata[c*DW +: DW];
  endtask

  task automatic m_reset();
    if (m_acc >= 0 && m_we && m_addr < DEPTH) known[m_addr[7:0]] = 1'b0;
    m_acc = -1; m_own = -1; m_idle = 0; m_last = N - 1; m_gnt = 0;
    m_ack = '0; m_err = 1'b0; m_rdata = '0; m_rd_chk = 1'b0;
  endtask

  task automatic m_step();
    logic [N-1:0] prev;
    bit inr;
    prev = m_ack;
    m_ack = '0; m_err = 1'b0; m_rdata = '0; m_rd_chk = 1'b0;
    if (m_acc >= 0) begin
      inr = m_addr < DEPTH;
      m_ack[m_acc] = 1'b1;
      m_err = !inr;
      if (!m_we) begin
        m_rd_chk = !inr || known[m_addr[7:0]];
        m_rdata  = inr ? mem[m_addr[7:0]] : '0;
      end else if (inr) begin
        mem[m_addr[7:0]] = m_wd;
        known[m_addr[7:0]] = 1'b1;
      end
      m_last = m_acc;
      m_own = lock[m_acc] ? m_acc : -1;
      m_idle = 0;
      m_acc = -1;
    end else if (m_own >= 0) begin
      if (req[m_own] && !prev[m_own]) m_take(m_own);
      else if (!lock[m_own]) m_own = -1;
      else begin
        m_idle++;
        if (m_idle == LMAX) begin
          m_ack[m_own] = 1'b1;
          m_err = 1'b1;
          m_own = -1;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_last + k) % N] && !prev[(m_last + k) % N]) begin
          m_take((m_last + k) % N);
          break;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ack", o_ack, m_ack);
    chk("err", o_err, m_err);
    if (m_rd_chk) chk("rdata", o_rdata, m_rdata);
    chk("ram_en", o_ram_en, m_acc >= 0 && m_addr < DEPTH);
    chk("gnt", o_gnt_id, m_gnt);
    chk("ack_onehot", $onehot0(o_ack), 1);
    if (m_acc >= 0) begin
      chk("ram_we", o_ram_we, m_we);
      chk("ram_addr", o_ram_addr, m_addr);
      if (m_we) chk("bus_wdata", ram_data, m_wd);
    end else chk("bus_float", ram_data, 8'hFF);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic core(input int i, input bit r, input bit w, input bit l, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    req[i] = r; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, o_ack, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_rdata"}, o_rdata, 0);
    chk({tag, "_gnt"}, o_gnt_id, 0);
    chk({tag, "_en"}, o_ram_en, 0);
    chk({tag, "_we"}, o_ram_we, 0);
    chk({tag, "_addr"}, o_ram_addr, 0);
    chk({tag, "_bus"}, ram_data, 8'hFF);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int s;
    s = $urandom_range(0, 15);
    return s == 0 ? 16'h0100 : s == 1 ? 16'hFFFF : s == 2 ? 16'h00FF : 16'h0010 + AW'($urandom_range(0, 7));
  endfunction

  initial begin
    int hold_acks;
    tick(); tick();
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    tick();
    // write 0xA5 to 0x10 from core 0, read it back from core 1
    core(0, 1, 1, 0, 16'h0010, 8'hA5);
    tick();
    chk("d1_en", o_ram_en, 1); chk("d1_we", o_ram_we, 1); chk("d1_bus", ram_data, 8'hA5);
    core(0, 0, 1, 0, 16'h0010, 8'hA5);
    tick();
    chk("d1_ack0", o_ack, 4'b0001); chk("d1_err0", o_err, 0);
    core(1, 1, 0, 0, 16'h0010, 8'h00);
    tick();
    chk("d1_gnt1", o_gnt_id, 1); chk("d1_rd_we", o_ram_we, 0);
    core(1, 0, 0, 0, 16'h0010, 8'h00);
    tick();
    chk("d1_ack1", o_ack, 4'b0010); chk("d1_rdata", o_rdata, 8'hA5); chk("d1_err1", o_err, 0);
    // reset again so LAST=3, then all four cores request at once
    rst_n = 1'b0;
    tick();
    chk_reset_outs("rst1");
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) core(i, 1, 0, 0, 16'h0010 + AW'(i), 8'h00);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk($sformatf("d2_ack_t%0d", t), o_ack, (t % 2 == 0) ? 4'(1 << (t / 2 - 1)) : 4'b0000);
      req = req & ~o_ack;
    end
    // core 2 locks across read then write of 0x20 while core 0 waits
    core(2, 1, 0, 1, 16'h0020, 8'h00);
    tick();
    chk("d3_gnt_a", o_gnt_id, 2);
    core(2, 0, 0, 1, 16'h0020, 8'h00);
    core(0, 1, 0, 0, 16'h0020, 8'h00);
    tick();
    chk("d3_ack_a", o_ack, 4'b0100);
    tick();
    chk("d3_hold", o_ack, 4'b0000);
    core(2, 1, 1, 1, 16'h0020, 8'h77);
    tick();
    chk("d3_gnt_b", o_gnt_id, 2); chk("d3_we_b", o_ram_we, 1); chk("d3_addr_b", o_ram_addr, 16'h0020);
    core(2, 0, 1, 0, 16'h0020, 8'h77);
    tick();
    chk("d3_ack_b", o_ack, 4'b0100);
    tick();
    chk("d3_gnt_c", o_gnt_id, 0); chk("d3_noack", o_ack, 4'b0000);
    req[0] = 1'b0;
    tick();
    chk("d3_ack_c", o_ack, 4'b0001); chk("d3_rdata", o_rdata, 8'h77);
    // core 3 sits on a lock without requesting until the timeout fires
    core(3, 1, 0, 1, 16'h0010, 8'h00);
    tick();
    chk("d4_gnt", o_gnt_id, 3);
    core(3, 0, 0, 1, 16'h0010, 8'h00);
    core(1, 1, 0, 0, 16'h0011, 8'h00);
    tick();
    chk("d4_ack", o_ack, 4'b1000); chk("d4_err", o_err, 0);
    hold_acks = 0;
    for (int t = 3; t <= 65; t++) begin
      tick();
      if (o_ack != 0) hold_acks++;
    end
    chk("d4_hold_quiet", hold_acks, 0);
    tick();
    chk("d4_to_ack", o_ack, 4'b1000); chk("d4_to_err", o_err, 1);
    lock[3] = 1'b0;
    tick();
    chk("d4_gnt1", o_gnt_id, 1);
    req[1] = 1'b0;
    tick();
    chk("d4_ack1", o_ack, 4'b0010); chk("d4_err1", o_err, 0);
    // out-of-range read
    core(0, 1, 0, 0, 16'h0100, 8'h00);
    tick();
    chk("d5_en", o_ram_en, 0);
    req[0] = 1'b0;
    tick();
    chk("d5_ack", o_ack, 4'b0001); chk("d5_err", o_err, 1); chk("d5_rdata", o_rdata, 0);
    // reset lands in the middle of a write access
    core(1, 1, 1, 0, 16'h0030, 8'h3C);
    tick();
    chk("d6_en", o_ram_en, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("d6_rst");
    req[1] = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("d6_noack", o_ack, 4'b0000);
    core(0, 1, 0, 0, 16'h0010, 8'h00);
    core(1, 1, 0, 0, 16'h0010, 8'h00);
    tick();
    chk("d6_gnt0", o_gnt_id, 0);
    req[0] = 1'b0;
    tick();
    chk("d6_ack0", o_ack, 4'b0001);
    tick();
    req[1] = 1'b0;
    tick();
    chk("d6_ack1", o_ack, 4'b0010);
    // randomized traffic; requesters drop REQ when acked and may withdraw early
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (o_ack[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0)
            core(i, 1, 1'($urandom_range(0, 1)), lock[i] | ($urandom_range(0, 5) == 0), rand_addr(),
                 8'($urandom));
        end else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        if (!req[i] && lock[i] && $urandom_range(0, 5) == 0) lock[i] = 1'b0;
      end
    end
    req = '0;
    lock = '0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter N_CORES, 4, number of requesting PLC cores (2..8).
REQ-002 Parameter ADDR_W, 16, address width.
REQ-003 Parameter DATA_W, 8, data width.
REQ-004 Parameter RAM_DEPTH, 256, implemented RAM words; addresses >= RAM_DEPTH are out of range.
REQ-005 Parameter LOCK_MAX, 64, maximum idle cycles a locked grant is held.
REQ-006 CLK  in  1  single clock; all state changes on rising edge.
REQ-007 RST_N  in  1  reset, asynchronous, active-low.
REQ-008 REQ  in  N_CORES  per-core access request.
REQ-009 WE  in  N_CORES  per-core write (1) / read (0) qualifier.
REQ-010 LOCK  in  N_CORES  per-core request to keep the grant after access (read-modify-write).
REQ-011 ADDR  in  N_CORES*ADDR_W  per-core address, core i at slice i.
REQ-012 WDATA  in  N_CORES*DATA_W  per-core write data, core i at slice i.
REQ-013 ACK  out  N_CORES  one-cycle completion pulse per core.
REQ-014 ERR  out  1  valid with ACK: out-of-range access or lock timeout.
REQ-015 RDATA  out  DATA_W  read data, valid only in the ACK cycle of a read.
REQ-016 GNT_ID  out  $clog2(N_CORES)  currently granted core.
REQ-017 RAM_EN, RAM_WE  out  1 each  RAM enables.
REQ-018 RAM_ADDR  out  16  RAM address.
REQ-019 RAM_DATA  inout  8  shared RAM data bus.

Function
REQ-020 FSM states IDLE, ACCESS, HOLD.
REQ-021 IDLE: if any REQ is high at a rising edge, select the winner by round-robin starting at (LAST+1) mod N_CORES; latch its WE/ADDR/WDATA; set GNT_ID; go to ACCESS.
REQ-022 ACCESS lasts exactly one cycle: RAM_EN=1, RAM_WE=latched WE, RAM_ADDR=latched ADDR.
REQ-023 RAM_DATA is driven with latched WDATA only in ACCESS with WE=1; it is high-Z in every other cycle.
REQ-024 At the edge ending ACCESS: capture RAM_DATA into RDATA on reads; set LAST=GNT_ID; assert ACK[GNT_ID] for the following cycle.
REQ-025 Latency: REQ sampled at edge k, access in cycle k+1, ACK/RDATA in cycle k+2.
REQ-026 Out-of-range ADDR: in ACCESS, RAM_EN=0; ACK still pulses with ERR=1 and RDATA=0.
REQ-027 After ACCESS: LOCK[GNT_ID]=1 goes to HOLD, otherwise IDLE.
REQ-028 HOLD: only the locked core is served. Its REQ re-enters ACCESS directly, bypassing arbitration. LOCK low with no REQ returns to IDLE.
REQ-029 HOLD idle counter increments each HOLD cycle without REQ. On reaching LOCK_MAX: release to IDLE and pulse ACK[GNT_ID] with ERR=1.
REQ-030 In the ACK cycle, REQ of the acknowledged core is masked from arbitration. A requester must drop REQ on ACK, or its request is taken as new from the next edge.
REQ-031 Simultaneous REQ from all cores: serviced in strict rotation; no core waits more than N_CORES accesses.
REQ-032 REQ dropped after latching does not abort the access; REQ dropped before sampling is ignored.
REQ-033 At most one ACK bit is high in any cycle.

Reset
REQ-034 RST_N low forces IDLE immediately: ACK=0, ERR=0, RDATA=0, GNT_ID=0, LAST=N_CORES-1, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DATA=Z, counter=0.
REQ-035 Reset during ACCESS aborts the access with no ACK. RAM contents are undefined for a write aborted by reset.

Structure
REQ-036 Package ram_arb_pkg holds the FSM state enum and default width/depth constants.
REQ-037 Sub-module rr_picker: combinational round-robin picker (request vector, last grant) -> (valid, index).

Verification
REQ-038 Write from core 0 (ADDR=0x0010, WDATA=0xA5), then read from core 1 at the same address -> ACK[1] two cycles after its REQ, RDATA=0xA5, ERR=0.
REQ-039 All four cores assert REQ in the same cycle with LAST=3 -> ACKs in order 0,1,2,3, one access per two cycles.
REQ-040 Core 2 sets LOCK with a read at 0x20, then writes 0x20 while core 0 is requesting -> core 0 gets no ACK until core 2 drops LOCK; 0x20 holds core 2's value.
REQ-041 Core 3 holds LOCK with no REQ for LOCK_MAX cycles -> ACK[3] pulse with ERR=1, FSM returns to IDLE, pending core 1 is then served.
REQ-042 Read at ADDR=0x0100 -> RAM_EN stays 0, ACK with ERR=1, RDATA=0.
REQ-043 RST_N pulsed low during a write ACCESS -> no ACK, RAM_DATA high-Z, all outputs at reset values, next request arbitrated from core 0.
